// File: rtl/hdmi_packet_pkg.sv
// Shared constants, types and the BCH(64,56)/(32,24) parity step for the HDMI data-island packet path.
// Used by both the transmit assembler and this receive-side disassembler.
package hdmi_packet_pkg;

    localparam logic [7:0] BCH_POLY     = 8'h83;
    localparam int         PACKET_BEATS = 32;
    localparam int         HEADER_BITS  = 24;
    localparam int         SUB_BITS     = 56;
    localparam int         ECC_BITS     = 8;
    localparam int         BEAT_W       = $clog2(PACKET_BEATS);

    typedef logic [BEAT_W-1:0]   beat_t;
    typedef logic [ECC_BITS-1:0] ecc_t;

    // One serial LFSR step of the BCH parity generator, LSB-first.
    function automatic ecc_t next_ecc(input ecc_t ecc, input logic data_bit);
        return (ecc[0] ^ data_bit) ? ((ecc >> 1) ^ BCH_POLY) : (ecc >> 1);
    endfunction

endpackage

// File: rtl/packet_ecc_accumulator.sv
// Folds BITS_PER_BEAT data bits per accepted beat into a BCH parity accumulator,
// stopping by itself once DATA_BEATS beats of data have been absorbed.
module packet_ecc_accumulator
    import hdmi_packet_pkg::*;
#(
    parameter int BITS_PER_BEAT = 1,
    parameter int DATA_BEATS    = 24
) (
    input  logic                     clk_pixel,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     step,
    input  logic [BITS_PER_BEAT-1:0] bits,
    output ecc_t                     ecc
);

    localparam int                CNT_W = $clog2(DATA_BEATS + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DATA_BEATS);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_base;
    ecc_t             ecc_base;
    ecc_t             ecc_stepped;

    // clear and step together means "first beat of a packet": start from zero this very beat.
    always_comb begin
        ecc_base    = clear ? '0 : ecc;
        count_base  = clear ? '0 : count;
        ecc_stepped = ecc_base;
        for (int i = 0; i < BITS_PER_BEAT; i++) begin
            ecc_stepped = next_ecc(ecc_stepped, bits[i]);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            ecc   <= '0;
            count <= '0;
        end else if (step && (count_base < LIMIT)) begin
            ecc   <= ecc_stepped;
            count <= count_base + 1'b1;
        end else if (clear) begin
            ecc   <= '0;
            count <= '0;
        end
    end

endmodule

// File: rtl/packet_disassembler.sv
// Rebuilds an HDMI data-island packet (24-bit header, four 56-bit subpackets) from 32 beats
// of 9-bit pixel-stream data and reports BCH parity status for each of the five blocks.
module packet_disassembler
    import hdmi_packet_pkg::*;
#(
    parameter bit CHECK_ECC = 1'b1
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   packet_start,
    input  logic [8:0]             packet_data,
    output logic [HEADER_BITS-1:0] header,
    output logic [SUB_BITS-1:0]    sub [3:0],
    output logic                   header_ecc_ok,
    output logic [3:0]             sub_ecc_ok,
    output logic                   packet_valid
);

    localparam int    BCH4_BITS = HEADER_BITS + ECC_BITS;
    localparam int    BCHN_BITS = SUB_BITS + ECC_BITS;
    localparam beat_t LAST_BEAT = beat_t'(PACKET_BEATS - 1);

    beat_t                counter;
    beat_t                idx;
    logic                 synced;
    logic                 accept;
    logic                 first_beat;
    logic                 last_beat;
    logic [BCH4_BITS-1:0] bch4_cap;
    logic [BCH4_BITS-1:0] bch4_nxt;
    logic [BCHN_BITS-1:0] bch_cap [3:0];
    logic [BCHN_BITS-1:0] bch_nxt [3:0];
    ecc_t                 acc4;
    ecc_t                 acc [3:0];

    // Handshake: enable is a pure beat qualifier with no backpressure; a beat is consumed on every
    // clock where enable is high and the receiver is synced (or packet_start marks beat 0).
    always_comb begin
        idx        = packet_start ? '0 : counter;
        accept     = enable && (synced || packet_start);
        first_beat = accept && (idx == '0);
        last_beat  = accept && (idx == LAST_BEAT);
        bch4_nxt      = bch4_cap;
        bch4_nxt[idx] = packet_data[0];
        for (int i = 0; i < 4; i++) begin
            bch_nxt[i]                = bch_cap[i];
            bch_nxt[i][{idx, 1'b0}]   = packet_data[1+i];
            bch_nxt[i][{idx, 1'b1}]   = packet_data[5+i];
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            counter  <= '0;
            synced   <= 1'b0;
            bch4_cap <= '0;
            for (int i = 0; i < 4; i++) begin
                bch_cap[i] <= '0;
            end
        end else if (accept) begin
            counter  <= idx + 1'b1;
            synced   <= 1'b1;
            bch4_cap <= bch4_nxt;
            for (int i = 0; i < 4; i++) begin
                bch_cap[i] <= bch_nxt[i];
            end
        end
    end

    packet_ecc_accumulator #(
        .BITS_PER_BEAT (1),
        .DATA_BEATS    (HEADER_BITS)
    ) u_header_ecc (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .clear     (first_beat),
        .step      (accept),
        .bits      (packet_data[0:0]),
        .ecc       (acc4)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sub_ecc
        packet_ecc_accumulator #(
            .BITS_PER_BEAT (2),
            .DATA_BEATS    (SUB_BITS / 2)
        ) u_sub_ecc (
            .clk_pixel (clk_pixel),
            .reset     (reset),
            .clear     (first_beat),
            .step      (accept),
            .bits      ({packet_data[5+g], packet_data[1+g]}),
            .ecc       (acc[g])
        );
    end

    // Parity is compared against the next-state capture so the final parity bit of beat 31 counts.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            header        <= '0;
            header_ecc_ok <= 1'b0;
            sub_ecc_ok    <= '0;
            packet_valid  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sub[i] <= '0;
            end
        end else begin
            packet_valid <= last_beat;
            if (last_beat) begin
                header        <= bch4_nxt[HEADER_BITS-1:0];
                header_ecc_ok <= !CHECK_ECC || (acc4 == bch4_nxt[HEADER_BITS +: ECC_BITS]);
                for (int i = 0; i < 4; i++) begin
                    sub[i]        <= bch_nxt[i][SUB_BITS-1:0];
                    sub_ecc_ok[i] <= !CHECK_ECC || (acc[i] == bch_nxt[i][SUB_BITS +: ECC_BITS]);
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_disassembler.sv
// Directed bench for packet_disassembler: builds packets from a header/subpacket description,
// drives them beat by beat and checks each valid pulse against hand-derived expectations.
module tb_packet_disassembler;

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic        enable;
    logic        packet_start;
    logic [8:0]  packet_data;
    logic [23:0] header;
    logic [55:0] sub [3:0];
    logic        header_ecc_ok;
    logic [3:0]  sub_ecc_ok;
    logic        packet_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk_pixel = ~clk_pixel;

    packet_disassembler #(.CHECK_ECC(1'b1)) dut (
        .clk_pixel     (clk_pixel),
        .reset         (reset),
        .enable        (enable),
        .packet_start  (packet_start),
        .packet_data   (packet_data),
        .header        (header),
        .sub           (sub),
        .header_ecc_ok (header_ecc_ok),
        .sub_ecc_ok    (sub_ecc_ok),
        .packet_valid  (packet_valid)
    );

    int cyc = 0;
    always @(posedge clk_pixel) cyc <= cyc + 1;

    // Every valid pulse is snapshotted so checks can run after the fact.
    int          valid_cnt = 0;
    logic [23:0] snap_hdr [16];
    logic [55:0] snap_sub [16][4];
    logic        snap_hok [16];
    logic [3:0]  snap_sok [16];
    int          snap_cyc [16];

    always @(negedge clk_pixel) begin
        if (packet_valid === 1'b1) begin
            if (valid_cnt < 16) begin
                snap_hdr[valid_cnt] = header;
                snap_hok[valid_cnt] = header_ecc_ok;
                snap_sok[valid_cnt] = sub_ecc_ok;
                snap_cyc[valid_cnt] = cyc;
                for (int i = 0; i < 4; i++) snap_sub[valid_cnt][i] = sub[i];
            end
            valid_cnt++;
        end
    end

    // Packet under construction.
    logic [23:0] t_hdr;
    logic [7:0]  t_p4;
    logic [55:0] t_sub [4];
    logic [7:0]  t_p [4];
    logic [23:0] c_hdr;
    logic [55:0] c_sub [4];

    task automatic check_bits(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bch(input logic [63:0] d, input int n);
        logic [7:0] e;
        logic       fb;
        e = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = e[0] ^ d[i];
            e  = {1'b0, e[7:1]};
            if (fb) e = e ^ 8'h83;
        end
        return e;
    endfunction

    task automatic set_parity();
        t_p4 = bch({40'b0, t_hdr}, 24);
        for (int i = 0; i < 4; i++) t_p[i] = bch({8'b0, t_sub[i]}, 56);
    endtask

    function automatic logic [8:0] beat_word(input int k);
        logic [31:0] b4;
        logic [63:0] bs;
        logic [8:0]  w;
        b4   = {t_p4, t_hdr};
        w[0] = b4[k];
        for (int i = 0; i < 4; i++) begin
            bs       = {t_p[i], t_sub[i]};
            w[1+i]   = bs[2*k];
            w[5+i]   = bs[2*k+1];
        end
        return w;
    endfunction

    task automatic drive_beat(input logic s, input logic [8:0] d);
        @(negedge clk_pixel);
        enable       = 1'b1;
        packet_start = s;
        packet_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_pixel);
            enable       = 1'b0;
            packet_start = 1'b0;
            packet_data  = 9'($urandom_range(0, 511));
        end
    endtask

    task automatic send_packet(input logic start_first, input int stall_at, input int stall_len,
                               input int n_beats, output int first_c, output int last_c);
        first_c = 0;
        last_c  = 0;
        for (int k = 0; k < n_beats; k++) begin
            if (k == stall_at) idle(stall_len);
            drive_beat(start_first && (k == 0), beat_word(k));
            if (k == 0) first_c = cyc;
            last_c = cyc;
        end
    endtask

    task automatic check_packet(input string tag, input int slot, input int exp_count,
                                input int first_c, input int last_c, input int exp_lat,
                                input logic exp_hok, input logic [3:0] exp_sok);
        check_bits({tag, "_count"}, 64'(valid_cnt), 64'(exp_count));
        check_bits({tag, "_lat1"}, 64'(snap_cyc[slot] - last_c), 64'd1);
        check_bits({tag, "_lat"}, 64'(snap_cyc[slot] - first_c), 64'(exp_lat));
        check_bits({tag, "_hdr"}, 64'(snap_hdr[slot]), 64'(t_hdr));
        for (int i = 0; i < 4; i++)
            check_bits($sformatf("%s_sub%0d", tag, i), 64'(snap_sub[slot][i]), 64'(t_sub[i]));
        check_bits({tag, "_hok"}, 64'(snap_hok[slot]), 64'(exp_hok));
        check_bits({tag, "_sok"}, 64'(snap_sok[slot]), 64'(exp_sok));
    endtask

    int f1, l1, f2, l2;

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        packet_start = 1'b0;
        packet_data  = '0;
        repeat (3) @(negedge clk_pixel);
        check_bits("rst_hdr", 64'(header), 64'd0);
        check_bits("rst_sub0", 64'(sub[0]), 64'd0);
        check_bits("rst_hok", 64'(header_ecc_ok), 64'd0);
        check_bits("rst_sok", 64'(sub_ecc_ok), 64'd0);
        check_bits("rst_valid", 64'(packet_valid), 64'd0);
        reset = 1'b0;
        idle(2);

        // 1: all-zero packet
        t_hdr = '0;
        for (int i = 0; i < 4; i++) t_sub[i] = '0;
        set_parity();
        send_packet(1'b1, -1, 0, 32, f1, l1);
        idle(3);
        check_packet("s1", 0, 1, f1, l1, 32, 1'b1, 4'hF);

        // 2: header 1 with hand-derived parity 4A, then a corrupted parity bit
        t_hdr = 24'h000001;
        t_p4  = 8'h4A;
        send_packet(1'b1, -1, 0, 32, f1, l1);
        idle(3);
        check_packet("s2a", 1, 2, f1, l1, 32, 1'b1, 4'hF);
        t_p4 = 8'h4B;
        send_packet(1'b1, -1, 0, 32, f1, l1);
        idle(3);
        check_packet("s2b", 2, 3, f1, l1, 32, 1'b0, 4'hF);

        // 3: mixed data, single-bit error in subpacket 2 bit 37
        t_hdr    = 24'hA5C31E;
        t_sub[0] = 56'h0123456789ABCD;
        t_sub[1] = 56'hFEDCBA98765432;
        t_sub[2] = 56'h5A5AF00F3C3CC3;
        t_sub[3] = 56'hDEADBEEFCAFE01;
        set_parity();
        t_sub[2][37] = ~t_sub[2][37];
        send_packet(1'b1, -1, 0, 32, f1, l1);
        idle(3);
        check_packet("s3", 3, 4, f1, l1, 32, 1'b1, 4'b1011);

        // 4: same packet unflipped with a 5-clock stall at beat 12
        t_sub[2][37] = ~t_sub[2][37];
        send_packet(1'b1, 12, 5, 32, f1, l1);
        idle(3);
        check_packet("s4", 4, 5, f1, l1, 37, 1'b1, 4'hF);

        // 5: restart at beat 17 discards the partial packet
        send_packet(1'b1, -1, 0, 17, f1, l1);
        t_hdr    = 24'h123456;
        t_sub[0] = 56'h00000000000080;
        t_sub[1] = 56'h80000000000000;
        t_sub[2] = 56'h13579BDF02468A;
        t_sub[3] = 56'hFFFFFFFFFFFFFF;
        set_parity();
        send_packet(1'b1, -1, 0, 32, f1, l1);
        idle(3);
        check_packet("s5", 5, 6, f1, l1, 32, 1'b1, 4'hF);

        // 6: back-to-back packets, packet_start only on the first
        t_hdr    = 24'h0F0F0F;
        t_sub[0] = 56'h11111111111111;
        t_sub[1] = 56'h22222222222222;
        t_sub[2] = 56'h33333333333333;
        t_sub[3] = 56'h44444444444444;
        set_parity();
        c_hdr = t_hdr;
        for (int i = 0; i < 4; i++) c_sub[i] = t_sub[i];
        send_packet(1'b1, -1, 0, 32, f1, l1);
        t_hdr    = 24'h8000FF;
        t_sub[0] = 56'hA0A0A0A0A0A0A0;
        t_sub[1] = 56'h0B0B0B0B0B0B0B;
        t_sub[2] = 56'hC3C3C3C3C3C3C3;
        t_sub[3] = 56'h0000000000DEAD;
        set_parity();
        send_packet(1'b0, -1, 0, 32, f2, l2);
        idle(3);
        check_packet("s6b", 7, 8, f2, l2, 32, 1'b1, 4'hF);
        t_hdr = c_hdr;
        for (int i = 0; i < 4; i++) t_sub[i] = c_sub[i];
        check_packet("s6a", 6, 8, f1, l1, 32, 1'b1, 4'hF);

        // 7: reset at beat 20, then unsynced beats must be ignored
        send_packet(1'b1, -1, 0, 20, f1, l1);
        @(negedge clk_pixel);
        reset       = 1'b1;
        enable      = 1'b1;
        packet_data = beat_word(20);
        @(negedge clk_pixel);
        reset = 1'b0;
        check_bits("s7_hdr", 64'(header), 64'd0);
        for (int i = 0; i < 4; i++)
            check_bits($sformatf("s7_sub%0d", i), 64'(sub[i]), 64'd0);
        check_bits("s7_hok", 64'(header_ecc_ok), 64'd0);
        check_bits("s7_sok", 64'(sub_ecc_ok), 64'd0);
        check_bits("s7_valid", 64'(packet_valid), 64'd0);
        send_packet(1'b0, -1, 0, 32, f2, l2);
        idle(3);
        check_bits("s7_count", 64'(valid_cnt), 64'd8);
        check_bits("s7_hdr_hold", 64'(header), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
